// File: rtl/routing_ni_vc.sv
// Local-port routing stage of the network injector: flit FIFO, per-packet VC
// allocation, streaming switch-allocation requests and sticky protocol-error flag.
module routing_ni_vc #(
    parameter int FLIT_SIZE      = 64,
    parameter int FLIT_TYPE_SIZE = 2,
    parameter int NUM_VC         = 2,
    parameter int BUF_DEPTH      = 2,
    parameter int VC_W           = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_p,
    input  logic                      Req,
    input  logic [FLIT_SIZE-1:0]      Flit,
    input  logic [FLIT_TYPE_SIZE-1:0] FlitType,
    input  logic                      BroadcastFlit,
    input  logic [NUM_VC-1:0]         Grant_VA_FromL,
    input  logic [NUM_VC-1:0]         Grant_SA_FromL,
    output logic [FLIT_SIZE-1:0]      FlitOut,
    output logic [FLIT_TYPE_SIZE-1:0] FlitTypeOut,
    output logic                      BroadcastFlitL,
    output logic [NUM_VC-1:0]         Request_VA_L,
    output logic [NUM_VC-1:0]         Request_SA_L,
    output logic [VC_W-1:0]           VcOut,
    output logic                      Avail,
    output logic                      Error
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_HEADER      = FLIT_TYPE_SIZE'(2'b10);
    localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_BODY        = FLIT_TYPE_SIZE'(2'b00);
    localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_TAIL        = FLIT_TYPE_SIZE'(2'b01);
    localparam logic [FLIT_TYPE_SIZE-1:0] TYPE_HEADER_TAIL = FLIT_TYPE_SIZE'(2'b11);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                    state;
    logic [FLIT_SIZE-1:0]      flit_mem  [BUF_DEPTH];
    logic [FLIT_TYPE_SIZE-1:0] type_mem  [BUF_DEPTH];
    logic                      bcast_mem [BUF_DEPTH];
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [CNT_W-1:0]          count;

    logic                      empty;
    logic                      full;
    logic [FLIT_TYPE_SIZE-1:0] head_type;
    logic                      head_is_header;
    logic                      head_is_last;
    logic                      sa_hit;
    logic                      pop_now;
    logic                      discard;
    logic                      pop;
    logic                      push;
    logic [VC_W-1:0]           va_idx;

    assign empty          = (count == '0);
    assign full           = (count == CNT_W'(BUF_DEPTH));
    assign head_type      = type_mem[rd_ptr];
    assign head_is_header = (head_type == TYPE_HEADER) || (head_type == TYPE_HEADER_TAIL);
    assign head_is_last   = (head_type == TYPE_TAIL) || (head_type == TYPE_HEADER_TAIL);

    // Only the grant bit of the VC this packet holds may pop the FIFO.
    always_comb begin
        sa_hit = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (VcOut == VC_W'(i) && Grant_SA_FromL[i]) sa_hit = 1'b1;
        end
    end

    always_comb begin
        va_idx = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (Grant_VA_FromL[i]) va_idx = VC_W'(i);
        end
    end

    assign pop_now = (state == ACTIVE) && !empty && sa_hit;
    assign discard = (state == IDLE) && !empty && !head_is_header;
    assign pop     = pop_now || discard;
    assign Avail   = !full || pop_now;
    assign push    = Req && Avail;

    assign FlitOut        = empty ? '0 : flit_mem[rd_ptr];
    assign FlitTypeOut    = empty ? '0 : head_type;
    assign BroadcastFlitL = empty ? 1'b0 : bcast_mem[rd_ptr];
    assign Request_VA_L   = ((state == IDLE) && !empty && head_is_header) ? '1 : '0;
    assign Request_SA_L   = ((state == ACTIVE) && !empty) ? (NUM_VC'(1) << VcOut) : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            flit_mem[wr_ptr]  <= Flit;
            type_mem[wr_ptr]  <= FlitType;
            bcast_mem[wr_ptr] <= BroadcastFlit;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // A VC is held from the VA grant until the flit closing the packet leaves.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state <= IDLE;
            VcOut <= '0;
            Error <= 1'b0;
        end else begin
            if ((Req && !Avail) || discard) Error <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty && head_is_header && (Grant_VA_FromL != '0)) begin
                        VcOut <= va_idx;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop_now && head_is_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_routing_ni_vc.sv
// Directed bench for routing_ni_vc: a vector table for the packet flows plus
// hand-written sequences for overflow and asynchronous reset mid-packet.
module tb_routing_ni_vc;

    localparam logic [1:0] HDR  = 2'b10;
    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] TAIL = 2'b01;
    localparam logic [1:0] HT   = 2'b11;
    localparam int NVEC = 24;

    typedef struct {
        logic        req;
        logic [63:0] flit;
        logic [1:0]  ftype;
        logic        bc;
        logic [1:0]  gva;
        logic [1:0]  gsa;
        logic [63:0] e_flit;
        logic [1:0]  e_type;
        logic        e_bc;
        logic [1:0]  e_va;
        logic [1:0]  e_sa;
        logic        e_vc;
        logic        e_avail;
        logic        e_err;
    } vec_t;

    logic        clk;
    logic        rst_p;
    logic        req;
    logic [63:0] flit;
    logic [1:0]  flit_type;
    logic        bcast;
    logic [1:0]  grant_va;
    logic [1:0]  grant_sa;
    logic [63:0] flit_out;
    logic [1:0]  flit_type_out;
    logic        bcast_out;
    logic [1:0]  req_va;
    logic [1:0]  req_sa;
    logic        vc_out;
    logic        avail;
    logic        error;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NVEC];

    routing_ni_vc #(
        .FLIT_SIZE(64), .FLIT_TYPE_SIZE(2), .NUM_VC(2), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .rst_p(rst_p), .Req(req), .Flit(flit), .FlitType(flit_type),
        .BroadcastFlit(bcast), .Grant_VA_FromL(grant_va), .Grant_SA_FromL(grant_sa),
        .FlitOut(flit_out), .FlitTypeOut(flit_type_out), .BroadcastFlitL(bcast_out),
        .Request_VA_L(req_va), .Request_SA_L(req_sa), .VcOut(vc_out),
        .Avail(avail), .Error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change mid-cycle after the falling edge; outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic r, input logic [63:0] f, input logic [1:0] t,
                                 input logic b, input logic [1:0] va, input logic [1:0] sa);
        @(negedge clk);
        req = r; flit = f; flit_type = t; bcast = b; grant_va = va; grant_sa = sa;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("v%0d flit", idx),  flit_out,      v.e_flit);
        checkVal($sformatf("v%0d type", idx),  flit_type_out, 64'(v.e_type));
        checkVal($sformatf("v%0d bcast", idx), bcast_out,     64'(v.e_bc));
        checkVal($sformatf("v%0d req_va", idx), req_va,       64'(v.e_va));
        checkVal($sformatf("v%0d req_sa", idx), req_sa,       64'(v.e_sa));
        checkVal($sformatf("v%0d vc", idx),    vc_out,        64'(v.e_vc));
        checkVal($sformatf("v%0d avail", idx), avail,         64'(v.e_avail));
        checkVal($sformatf("v%0d error", idx), error,         64'(v.e_err));
    endtask

    initial begin
        // req, flit, type, bc, gva, gsa | e_flit, e_type, e_bc, e_va, e_sa, e_vc, e_avail, e_err
        vecs[0]  = '{0, 64'h0,  BODY, 0, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[1]  = '{1, 64'hA1, HT,   1, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[2]  = '{0, 64'h0,  BODY, 0, 2'b10, 2'b00, 64'hA1, HT,    1, 2'b11, 2'b00, 0, 1, 0};
        vecs[3]  = '{0, 64'h0,  BODY, 0, 2'b00, 2'b10, 64'hA1, HT,    1, 2'b00, 2'b10, 1, 1, 0};
        vecs[4]  = '{0, 64'h0,  BODY, 0, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 1, 1, 0};
        vecs[5]  = '{1, 64'hB1, HDR,  0, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 1, 1, 0};
        vecs[6]  = '{1, 64'hB2, BODY, 0, 2'b01, 2'b00, 64'hB1, HDR,   0, 2'b11, 2'b00, 1, 1, 0};
        vecs[7]  = '{1, 64'hB3, BODY, 0, 2'b00, 2'b01, 64'hB1, HDR,   0, 2'b00, 2'b01, 0, 1, 0};
        vecs[8]  = '{1, 64'hB4, TAIL, 0, 2'b00, 2'b01, 64'hB2, BODY,  0, 2'b00, 2'b01, 0, 1, 0};
        vecs[9]  = '{0, 64'h0,  BODY, 0, 2'b00, 2'b01, 64'hB3, BODY,  0, 2'b00, 2'b01, 0, 1, 0};
        vecs[10] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b01, 64'hB4, TAIL,  0, 2'b00, 2'b01, 0, 1, 0};
        vecs[11] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[12] = '{1, 64'hC1, HDR,  0, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[13] = '{1, 64'hC2, TAIL, 0, 2'b10, 2'b00, 64'hC1, HDR,   0, 2'b11, 2'b00, 0, 1, 0};
        vecs[14] = '{1, 64'hC3, HT,   0, 2'b00, 2'b10, 64'hC1, HDR,   0, 2'b00, 2'b10, 1, 1, 0};
        vecs[15] = '{0, 64'h0,  BODY, 0, 2'b01, 2'b11, 64'hC2, TAIL,  0, 2'b00, 2'b10, 1, 1, 0};
        vecs[16] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b00, 64'hC3, HT,    0, 2'b11, 2'b00, 1, 1, 0};
        vecs[17] = '{0, 64'h0,  BODY, 0, 2'b01, 2'b00, 64'hC3, HT,    0, 2'b11, 2'b00, 1, 1, 0};
        vecs[18] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b10, 64'hC3, HT,    0, 2'b00, 2'b01, 0, 1, 0};
        vecs[19] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b01, 64'hC3, HT,    0, 2'b00, 2'b01, 0, 1, 0};
        vecs[20] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[21] = '{1, 64'hD1, BODY, 0, 2'b11, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 0, 1, 0};
        vecs[22] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b00, 64'hD1, BODY,  0, 2'b00, 2'b00, 0, 1, 0};
        vecs[23] = '{0, 64'h0,  BODY, 0, 2'b00, 2'b00, 64'h0,  2'b00, 0, 2'b00, 2'b00, 0, 1, 1};

        rst_p = 1'b1; req = 1'b0; flit = '0; flit_type = '0; bcast = 1'b0;
        grant_va = '0; grant_sa = '0;
        #12 rst_p = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].req, vecs[i].flit, vecs[i].ftype, vecs[i].bc,
                          vecs[i].gva, vecs[i].gsa);
            checkOutput(vecs[i], i);
        end

        // Overflow: fill both entries with SA withheld, then push into a full FIFO.
        @(negedge clk); rst_p = 1'b1; #2 rst_p = 1'b0;
        applyStimulus(1, 64'hE1, HDR, 0, 2'b00, 2'b00);
        checkVal("ovf avail0", avail, 1);
        checkVal("ovf err_clr", error, 0);
        applyStimulus(1, 64'hE2, BODY, 0, 2'b00, 2'b00);
        checkVal("ovf avail1", avail, 1);
        checkVal("ovf va", req_va, 2'b11);
        applyStimulus(1, 64'hE3, BODY, 0, 2'b00, 2'b00);
        checkVal("ovf full", avail, 0);
        checkVal("ovf err_pre", error, 0);
        applyStimulus(0, 64'h0, BODY, 0, 2'b00, 2'b00);
        checkVal("ovf err", error, 1);
        checkVal("ovf head", flit_out, 64'hE1);
        applyStimulus(0, 64'h0, BODY, 0, 2'b01, 2'b00);
        applyStimulus(1, 64'hE4, TAIL, 0, 2'b00, 2'b01);
        checkVal("ovf avail_pop", avail, 1);
        checkVal("ovf sa", req_sa, 2'b01);
        applyStimulus(0, 64'h0, BODY, 0, 2'b00, 2'b01);
        checkVal("ovf head2", flit_out, 64'hE2);
        applyStimulus(0, 64'h0, BODY, 0, 2'b00, 2'b01);
        checkVal("ovf head3", flit_out, 64'hE4);
        checkVal("ovf type3", flit_type_out, TAIL);
        applyStimulus(0, 64'h0, BODY, 0, 2'b00, 2'b00);
        checkVal("ovf idle_sa", req_sa, 0);
        checkVal("ovf idle_type", flit_type_out, 0);
        checkVal("ovf err_sticky", error, 1);

        // Asynchronous reset in the middle of an active packet.
        applyStimulus(1, 64'hF1, HDR, 0, 2'b00, 2'b00);
        applyStimulus(1, 64'hF2, BODY, 0, 2'b10, 2'b00);
        applyStimulus(0, 64'h0, BODY, 0, 2'b00, 2'b10);
        checkVal("rst pre_sa", req_sa, 2'b10);
        checkVal("rst pre_vc", vc_out, 1);
        #2 rst_p = 1'b1;
        #1;
        checkVal("rst flit", flit_out, 0);
        checkVal("rst sa", req_sa, 0);
        checkVal("rst va", req_va, 0);
        checkVal("rst vc", vc_out, 0);
        checkVal("rst avail", avail, 1);
        checkVal("rst err", error, 0);
        @(negedge clk); rst_p = 1'b0;
        applyStimulus(0, 64'h0, BODY, 0, 2'b00, 2'b10);
        checkVal("rst post_sa", req_sa, 0);
        checkVal("rst post_va", req_va, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
